// File: rtl/bank_rd_sched.sv
// Read scheduler for the four-bank RAM: FIFO-buffered requests issued as one-hot bank enables plus a latency-matched mux select.
// Optional issued-read counter `rd_count` is built when BANK_RD_SCHED_STATS_EN is defined.
module bank_rd_sched #(
  parameter int WORDSIZE   = 16,
  parameter int ADDRW      = 10,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDRW-1:0]            req_addr,
  input  logic                        wr_busy,
  output logic [3:0]                  bank_en,
  output logic [ADDRW-3:0]            bank_addr,
  output logic [3:0]                  sel,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        busy
`ifdef BANK_RD_SCHED_STATS_EN
  ,
  output logic [15:0]                 rd_count
`endif
);

  // WORDSIZE only documents the downstream mux width; it folds to zero here.
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1 + 0 * WORDSIZE;

  logic [ADDRW-1:0] fifo_q [FIFO_DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [3:0]       bank_en_q, bank_en_d;
  logic [ADDRW-3:0] bank_addr_q, bank_addr_d;
  logic [3:0]       sel_q [RD_LAT];
  logic [ADDRW-1:0] head;
  logic             push, pop, pipe_any;

  // Handshake: a request transfers at a rising edge where req_valid && req_ready;
  // req_ready depends only on registered occupancy, never on a same-edge pop.
  assign req_ready = (count_q != CNTW'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (count_q != '0) && !wr_busy;
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    bank_en_d   = '0;
    bank_addr_d = bank_addr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTRW'(1);
      bank_en_d   = 4'b0001 << head[ADDRW-1:ADDRW-2];
      bank_addr_d = head[ADDRW-3:0];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= req_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bank_en_q   <= '0;
      bank_addr_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bank_en_q   <= bank_en_d;
      bank_addr_q <= bank_addr_d;
    end
  end

  // Select delay line: stage RD_LAT-1 lines up with bank data arriving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) sel_q[i] <= '0;
    end else begin
      sel_q[0] <= bank_en_q;
      for (int i = 1; i < RD_LAT; i++) sel_q[i] <= sel_q[i-1];
    end
  end

  always_comb begin
    pipe_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pipe_any = pipe_any | (|sel_q[i]);
  end

  assign bank_en   = bank_en_q;
  assign bank_addr = bank_addr_q;
  assign sel       = sel_q[RD_LAT-1];
  assign count     = count_q;
  assign busy      = (count_q != '0) || (|bank_en_q) || pipe_any;

`ifdef BANK_RD_SCHED_STATS_EN
  logic [15:0] rd_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_count_q <= '0;
    else if (pop) rd_count_q <= rd_count_q + 16'd1;
  end

  assign rd_count = rd_count_q;
`endif

endmodule
